// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file for the DE stage with a per-register in-flight write
//   scoreboard. Each register has a saturating pending-write counter, so
//   several in-flight writers of one register can be tracked. Writes retire
//   from WB, and squashed writers are cancelled through the kill port.
//   The block stalls DE on a RAW hazard or when the destination counter is
//   saturated.
//
// Parameters
//   DBITS      data width of each register
//   REGNOBITS  register index width (2**REGNOBITS registers)
//   CNTBITS    pending-counter width (up to 2**CNTBITS-1 writers in flight)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   rs1_no/rs2_no, rsN_use     source indices and their use flags
//   issue_valid/wr/rd          instruction in DE trying to issue
//   wb_valid/rd/data           WB register write (retires one writer)
//   kill_valid/rd              squashed writer (retires without writing)
//   rs1_data/rs2_data          combinational source reads
//   stall                      DE must hold this cycle
//   busy_vec                   bit r set while register r has writers in flight
//   err_underflow              sticky; a retire hit a zero counter
//
// Optional feature
//   REGFILE_SB_WB_BYPASS_EN    forwards wb_data to same-cycle reads and drops
//                              the source stall when that WB retires the last
//                              in-flight writer.

module regfile_scoreboard #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REGNOBITS-1:0]      rs1_no,
    input  logic [REGNOBITS-1:0]      rs2_no,
    input  logic                      rs1_use,
    input  logic                      rs2_use,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REGNOBITS-1:0]      issue_rd,
    input  logic                      wb_valid,
    input  logic [REGNOBITS-1:0]      wb_rd,
    input  logic [DBITS-1:0]          wb_data,
    input  logic                      kill_valid,
    input  logic [REGNOBITS-1:0]      kill_rd,
    output logic [DBITS-1:0]          rs1_data,
    output logic [DBITS-1:0]          rs2_data,
    output logic                      stall,
    output logic [2**REGNOBITS-1:0]   busy_vec,
    output logic                      err_underflow
);

    localparam int unsigned NREG = 2**REGNOBITS;
    localparam logic [CNTBITS-1:0] CMAX = '1;

    logic [DBITS-1:0]   regs     [NREG];
    logic [CNTBITS-1:0] cnt      [NREG];
    logic [CNTBITS-1:0] cnt_next [NREG];

    logic               issue_fire;
    logic               underflow_any;
    logic               src1_busy;
    logic               src2_busy;
    logic               dst_sat;
    logic               inc;
    logic [1:0]         dec;
    logic [CNTBITS:0]   sum;

    // ---------------------------------------------------------------
    // Busy vector
    // ---------------------------------------------------------------
    always_comb begin
        busy_vec = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    // ---------------------------------------------------------------
    // Reads and hazard detection
    // ---------------------------------------------------------------
    always_comb begin
        rs1_data  = regs[rs1_no];
        rs2_data  = regs[rs2_no];
        src1_busy = rs1_use && (rs1_no != '0) && busy_vec[rs1_no];
        src2_busy = rs2_use && (rs2_no != '0) && busy_vec[rs2_no];
`ifdef REGFILE_SB_WB_BYPASS_EN
        if (wb_valid && (wb_rd != '0) && (wb_rd == rs1_no)) begin
            rs1_data = wb_data;
        end
        if (wb_valid && (wb_rd != '0) && (wb_rd == rs2_no)) begin
            rs2_data = wb_data;
        end
        // The WB in this cycle retires the only writer, so the forwarded
        // value is final -- unless a kill also drains the same register,
        // in which case the counts disagree and we keep stalling.
        if ((cnt[rs1_no] == CNTBITS'(1)) && wb_valid && (wb_rd == rs1_no) &&
            !(kill_valid && (kill_rd == rs1_no))) begin
            src1_busy = 1'b0;
        end
        if ((cnt[rs2_no] == CNTBITS'(1)) && wb_valid && (wb_rd == rs2_no) &&
            !(kill_valid && (kill_rd == rs2_no))) begin
            src2_busy = 1'b0;
        end
`endif
        dst_sat    = issue_wr && (issue_rd != '0) && (cnt[issue_rd] == CMAX);
        stall      = issue_valid && (src1_busy || src2_busy || dst_sat);
        issue_fire = issue_valid && !stall;
    end

    // ---------------------------------------------------------------
    // Counter next-state: cnt + inc - dwb - dkill in one step, clamped at 0.
    // inc can only occur when cnt < CMAX (a saturated rd stalls), so the
    // upper bound needs no clamp.
    // ---------------------------------------------------------------
    always_comb begin
        underflow_any = 1'b0;
        inc           = 1'b0;
        dec           = '0;
        sum           = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_next[r] = cnt[r];
            if (r != 0) begin
                inc = issue_fire && issue_wr && (issue_rd == REGNOBITS'(r));
                dec = {1'b0, wb_valid   && (wb_rd   == REGNOBITS'(r))} +
                      {1'b0, kill_valid && (kill_rd == REGNOBITS'(r))};
                sum = {1'b0, cnt[r]} + {{CNTBITS{1'b0}}, inc};
                if (sum < (CNTBITS+1)'(dec)) begin
                    cnt_next[r]   = '0;
                    underflow_any = 1'b1;
                end else begin
                    cnt_next[r] = CNTBITS'(sum - (CNTBITS+1)'(dec));
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_next[r];
            end
            if (wb_valid && (wb_rd != '0)) begin
                regs[wb_rd] <= wb_data;
            end
            if (underflow_any) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
